// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: packet-locked round-robin merge of N_SRC valid/ready byte streams into one registered output stream
module stream_rr_arbiter #(
  parameter int N_SRC        = 4,
  parameter int T_DATA_WIDTH = 8,
  parameter int T_ID_WIDTH   = $clog2(N_SRC)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_SRC*T_DATA_WIDTH-1:0] s_data,
  input  logic [N_SRC-1:0]              s_valid,
  input  logic [N_SRC-1:0]              s_last,
  output logic [N_SRC-1:0]              s_ready,
  output logic [T_DATA_WIDTH-1:0]       m_data,
  output logic                          m_valid,
  output logic                          m_last,
  output logic [T_ID_WIDTH-1:0]         m_id,
  input  logic                          m_ready,
  output logic                          busy
);
  typedef enum logic {IDLE, LOCK} state_t;
  state_t state_q, state_d;
  logic [T_ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d, grant_q, grant_d, m_id_q, m_id_d, pick;
  logic [T_DATA_WIDTH-1:0] m_data_q, m_data_d, sel_data;
  logic m_valid_q, m_valid_d, m_last_q, m_last_d, xfer, last_beat;
  // Descending scan so the requester closest to rr_ptr (in wrap order) wins.
  always_comb begin
    pick = rr_ptr_q;
    sel_data = '0;
    for (int k = N_SRC - 1; k >= 0; k--)
      if (s_valid[T_ID_WIDTH'((int'(rr_ptr_q) + k) % N_SRC)]) pick = T_ID_WIDTH'((int'(rr_ptr_q) + k) % N_SRC);
    for (int i = 0; i < N_SRC; i++)
      if (grant_q == T_ID_WIDTH'(i)) sel_data = s_data[i*T_DATA_WIDTH +: T_DATA_WIDTH];
  end
  assign s_ready   = (state_q == LOCK) ? (N_SRC'(1) << grant_q) & {N_SRC{~m_valid_q | m_ready}} : '0;
  assign xfer      = |(s_valid & s_ready);
  assign last_beat = s_last[grant_q];
  always_comb begin
    m_valid_d = xfer | (m_valid_q & ~m_ready);
    m_data_d  = xfer ? sel_data : m_data_q;
    m_last_d  = xfer ? last_beat : m_last_q;
    m_id_d    = xfer ? grant_q : m_id_q;
    grant_d   = (state_q == IDLE && |s_valid) ? pick : grant_q;
    state_d   = (state_q == IDLE && |s_valid) ? LOCK : (xfer && last_beat) ? IDLE : state_q;
    rr_ptr_d  = (xfer && last_beat) ? ((grant_q == T_ID_WIDTH'(N_SRC - 1)) ? '0 : grant_q + 1'b1) : rr_ptr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      m_id_q    <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      m_id_q    <= m_id_d;
    end
  end
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;
  assign m_id    = m_id_q;
  assign busy    = state_q == LOCK;
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb_stream_rr_arbiter: directed stimulus with a per-cycle behavioural model plus literal expectations for stream_rr_arbiter
module tb_stream_rr_arbiter;
  localparam int N = 4;
  logic clk = 1'b0, rst = 1'b1, m_ready = 1'b1;
  logic [N*8-1:0] s_data;
  logic [N-1:0] s_valid, s_last, s_ready;
  logic [7:0] m_data;
  logic m_valid, m_last, busy;
  logic [1:0] m_id;
  int checks = 0, failures = 0, cyc = 0;

  stream_rr_arbiter #(.N_SRC(N), .T_DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_id(m_id), .m_ready(m_ready), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Per-source packet queues: {last, data}
  logic [8:0] mem [N][64];
  int hd [N];
  int tl [N];
  logic [N-1:0] hs;

  task automatic push(input int s, input logic [7:0] d, input logic l);
    mem[s][tl[s]] = {l, d};
    tl[s]++;
  endtask

  initial begin
    s_valid = '0;
    s_last = '0;
    s_data = '0;
    forever begin
      @(negedge clk);
      #4 hs = s_valid & s_ready & {N{~rst}};
      @(posedge clk);
      #1 for (int i = 0; i < N; i++) if (hs[i]) hd[i]++;
      #2 for (int i = 0; i < N; i++) begin
        s_valid[i] = hd[i] != tl[i];
        s_data[i*8 +: 8] = mem[i][hd[i]][7:0];
        s_last[i] = mem[i][hd[i]][8];
      end
    end
  end

  // Output log of beats accepted downstream
  int log_id [256];
  int log_d [256];
  int log_l [256];
  int log_c [256];
  int log_n = 0;

  // Behavioural model: lock owner, search start, 1-deep output register
  bit mdl_on = 0, lk = 0, lk_n, ov = 0, ov_n, ol = 0, ol_n;
  int own = 0, own_n, ptr = 0, ptr_n, od = 0, od_n, oi = 0, oi_n;
  logic [N-1:0] er;

  initial forever begin
    @(negedge clk);
    er = (lk && (!ov || m_ready)) ? N'(1) << own : '0;
    if (mdl_on) begin
      chk("busy", busy, lk);
      chk("s_ready", s_ready, er);
      chk("m_valid", m_valid, ov);
      if (ov) begin
        chk("m_data", m_data, od);
        chk("m_last", m_last, ol);
        chk("m_id", m_id, oi);
      end
    end
    if (m_valid === 1'b1 && m_ready) begin
      log_id[log_n] = int'(m_id);
      log_d[log_n] = int'(m_data);
      log_l[log_n] = int'(m_last);
      log_c[log_n] = cyc;
      log_n++;
    end
    #4;
    lk_n = lk; own_n = own; ptr_n = ptr; ov_n = ov; od_n = od; ol_n = ol; oi_n = oi;
    if (rst) begin
      lk_n = 0; ptr_n = 0; ov_n = 0;
    end else begin
      if (ov && m_ready) ov_n = 0;
      if (lk && er[own] && s_valid[own]) begin
        ov_n = 1;
        od_n = int'(8'(s_data >> (own * 8)));
        ol_n = s_last[own];
        oi_n = own;
        if (s_last[own]) begin
          lk_n = 0;
          ptr_n = (own + 1) % N;
        end
      end
      if (!lk)
        for (int k = 0; k < N; k++)
          if (!lk_n && s_valid[(ptr + k) % N]) begin
            lk_n = 1;
            own_n = (ptr + k) % N;
          end
    end
    @(posedge clk);
    lk = lk_n; own = own_n; ptr = ptr_n; ov = ov_n; od = od_n; ol = ol_n; oi = oi_n;
    if (rst) mdl_on = 1;
  end

  task automatic wait_log(input int n);
    int b = 200;
    while (log_n < n && b > 0) begin
      @(posedge clk);
      b--;
    end
    #2 chk("log_count", log_n, n);
  endtask

  task automatic chk_log(input int i, input int id, input int d, input int l);
    chk("log_id", log_id[i], id);
    chk("log_data", log_d[i], d);
    chk("log_last", log_l[i], l);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    int base, b;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_id", m_id, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    #2;
    // Two 2-beat packets on sources 0 and 2
    base = log_n;
    push(0, 8'hA0, 0); push(0, 8'hA1, 1);
    push(2, 8'hC0, 0); push(2, 8'hC1, 1);
    wait_log(base + 4);
    chk_log(base, 0, 'hA0, 0); chk_log(base + 1, 0, 'hA1, 1);
    chk_log(base + 2, 2, 'hC0, 0); chk_log(base + 3, 2, 'hC1, 1);
    chk("pkt_gap", log_c[base + 2] - log_c[base + 1], 2);
    // Pointer now 3: sources 0,1,3 requesting are served 3,0,1
    base = log_n;
    push(0, 8'h01, 1); push(1, 8'h11, 1); push(3, 8'h31, 1);
    wait_log(base + 3);
    chk_log(base, 3, 'h31, 1); chk_log(base + 1, 0, 'h01, 1); chk_log(base + 2, 1, 'h11, 1);
    // All four sources with back-to-back single-beat packets
    do_reset();
    base = log_n;
    for (int k = 0; k < 2; k++)
      for (int s = 0; s < N; s++) push(s, 8'(16 * s + k), 1);
    wait_log(base + 8);
    for (int k = 0; k < 2; k++)
      for (int s = 0; s < N; s++) chk_log(base + 4 * k + s, s, 16 * s + k, 1);
    // Downstream stall after the first beat of a 3-beat packet
    m_ready = 1'b0;
    base = log_n;
    push(1, 8'hB0, 0); push(1, 8'hB1, 0); push(1, 8'hB2, 1);
    b = 20;
    while (!m_valid && b > 0) begin
      @(posedge clk);
      #2 b--;
    end
    chk("stall_valid", m_valid, 1);
    repeat (3) begin
      @(negedge clk);
      chk("stall_data", m_data, 'hB0);
      chk("stall_ready", s_ready, 0);
    end
    @(posedge clk);
    #2 m_ready = 1'b1;
    wait_log(base + 3);
    chk_log(base, 1, 'hB0, 0); chk_log(base + 1, 1, 'hB1, 0); chk_log(base + 2, 1, 'hB2, 1);
    // Source 0 pauses mid-packet while source 3 requests
    base = log_n;
    push(0, 8'hD0, 0);
    b = 20;
    while (hd[0] != tl[0] && b > 0) begin
      @(posedge clk);
      #2 b--;
    end
    chk("pause_pop", hd[0], tl[0]);
    push(3, 8'hE0, 1);
    repeat (2) begin
      @(negedge clk);
      chk("pause_busy", busy, 1);
      chk("pause_ready", s_ready, 'b0001);
    end
    @(posedge clk);
    #2 push(0, 8'hD1, 0); push(0, 8'hD2, 1);
    wait_log(base + 4);
    chk_log(base, 0, 'hD0, 0); chk_log(base + 1, 0, 'hD1, 0);
    chk_log(base + 2, 0, 'hD2, 1); chk_log(base + 3, 3, 'hE0, 1);
    // 8-beat packet at full throughput
    base = log_n;
    for (int k = 0; k < 8; k++) push(1, 8'(8'h40 + k), k == 7);
    wait_log(base + 8);
    for (int k = 0; k < 8; k++) begin
      chk_log(base + k, 1, 'h40 + k, int'(k == 7));
      chk("burst_cycle", log_c[base + k] - log_c[base], k);
    end
    // Reset during the second-beat transfer of a 4-beat packet (pointer was 2)
    base = log_n;
    for (int k = 0; k < 4; k++) push(2, 8'(8'hF0 + k), k == 3);
    b = 40;
    while (log_n == base && b > 0) begin
      @(negedge clk);
      #1 b--;
    end
    chk("rst_first_beat", log_n, base + 1);
    #1 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    push(0, 8'h77, 1);
    @(negedge clk);
    chk("mrst_m_valid", m_valid, 0);
    chk("mrst_s_ready", s_ready, 0);
    chk("mrst_busy", busy, 0);
    wait_log(base + 5);
    chk_log(base, 2, 'hF0, 0); chk_log(base + 1, 0, 'h77, 1);
    chk_log(base + 2, 2, 'hF1, 0); chk_log(base + 3, 2, 'hF2, 0); chk_log(base + 4, 2, 'hF3, 1);
    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
